// File: rtl/calc_game_io.sv
// Output engine of the calculator game: question generator, six-digit seven-segment printer, buzzer sequencer.
// Optional: define CALC_BUZZER_EN to drive the buzzer pattern; otherwise buzzer is tied low.
module calc_game_io #(
    parameter int HOLD_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  state,
    input  logic [2:0]  level,
    input  logic [2:0]  start_level,
    input  logic        startgame,
    input  logic [1:0]  score,
    input  logic [3:0]  response,
    input  logic [27:0] seed,
    output logic [24:0] phrase,
    output logic [3:0]  result,
    output logic [3:0]  value,
    output logic        gen_done,
    output logic        print_done,
    output logic        buz_done,
    output logic [7:0]  h5,
    output logic [7:0]  h4,
    output logic [7:0]  h3,
    output logic [7:0]  h2,
    output logic [7:0]  h1,
    output logic [7:0]  h0,
    output logic        buzzer
);
    localparam int CW = 16;
`ifdef CALC_BUZZER_EN
    localparam bit BUZ_EN = 1'b1;
`else
    localparam bit BUZ_EN = 1'b0;
`endif

    localparam logic [4:0] SYM_ADD = 5'd16, SYM_SUB = 5'd17, SYM_MUL = 5'd18;
    localparam logic [4:0] SYM_EQ = 5'd19, SYM_Q = 5'd20, SYM_BLANK = 5'd31;

    function automatic logic [7:0] glyph(input logic [4:0] s);
        case (s)
            5'd0:    glyph = 8'hC0;
            5'd1:    glyph = 8'hF9;
            5'd2:    glyph = 8'hA4;
            5'd3:    glyph = 8'hB0;
            5'd4:    glyph = 8'h99;
            5'd5:    glyph = 8'h92;
            5'd6:    glyph = 8'h82;
            5'd7:    glyph = 8'hF8;
            5'd8:    glyph = 8'h80;
            5'd9:    glyph = 8'h90;
            SYM_ADD: glyph = 8'h88;
            SYM_SUB: glyph = 8'hBF;
            SYM_MUL: glyph = 8'h89;
            SYM_EQ:  glyph = 8'hB7;
            SYM_Q:   glyph = 8'hAC;
            default: glyph = 8'hFF;
        endcase
    endfunction

    function automatic logic [3:0] red10(input logic [3:0] n);
        red10 = (n >= 4'd10) ? n - 4'd10 : n;
    endfunction

    logic [3:0]    prev_state;
    logic          entry;
    logic [7:0]    lfsr, r;
    logic [CW-1:0] cnt;
    logic [1:0]    lvl;
    logic          unused_seed;

    assign entry       = (state != prev_state);
    assign lvl         = (level >= 3'd1 && level <= 3'd3) ? level[1:0] : 2'd1;
    assign unused_seed = ^seed[27:8];

    // Question arithmetic for the latched random byte
    logic [3:0] x, y, ga, gb, gres;
    logic [4:0] gop;
    always_comb begin
        x    = red10(r[3:0]);
        y    = red10(r[7:4]);
        ga   = x;
        gb   = (y < 4'd9 - x) ? y : 4'd9 - x;
        gop  = SYM_ADD;
        gres = ga + gb;
        case (lvl)
            2'd2: begin
                ga   = (x > y) ? x : y;
                gb   = (x > y) ? y : x;
                gop  = SYM_SUB;
                gres = ga - gb;
            end
            2'd3: begin
                ga   = {2'b00, r[1:0]};
                gb   = {2'b00, r[3:2]};
                gop  = SYM_MUL;
                gres = ga * gb;
            end
            default: ;
        endcase
    end

    // Printer-side evaluation of whatever phrase is currently held
    logic [3:0] ev;
    always_comb begin
        case (phrase[19:15])
            SYM_ADD: ev = phrase[23:20] + phrase[13:10];
            SYM_SUB: ev = phrase[23:20] - phrase[13:10];
            SYM_MUL: ev = phrase[23:20] * phrase[13:10];
            default: ev = 4'd0;
        endcase
    end

    // Buzzer patterns are stored LSB-first, bit 0 plays on the entry cycle
    logic       is_buz, is_print;
    logic [3:0] pat;
    logic [2:0] plen;
    always_comb begin
        is_buz = 1'b1;
        pat    = 4'b0000;
        plen   = 3'd4;
        case (state)
            4'd6:    begin pat = 4'b0001; plen = 3'd2; end
            4'd5:    pat = 4'b0111;
            4'd7:    pat = 4'b0101;
            default: is_buz = 1'b0;
        endcase
        is_print = (state == 4'd1) || (state == 4'd3) || (state == 4'd8) || (state == 4'd10);
    end

    logic buzzer_q;
    assign buzzer = buzzer_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_state <= 4'd0;
            lfsr       <= 8'h5A;
            r          <= 8'h00;
            cnt        <= '0;
            phrase     <= {5{SYM_BLANK}};
            result     <= 4'd0;
            value      <= 4'd0;
            gen_done   <= 1'b0;
            print_done <= 1'b0;
            buz_done   <= 1'b0;
            buzzer_q   <= 1'b0;
        end else begin
            prev_state <= state;
            lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (entry) begin
                cnt        <= '0;
                gen_done   <= 1'b0;
                print_done <= 1'b0;
                buz_done   <= 1'b0;
                buzzer_q   <= BUZ_EN && is_buz && pat[0];
                if (state == 4'd2) r <= seed[7:0] ^ lfsr;
                if (state == 4'd3) value <= ev;
            end else begin
                if (cnt != '1) cnt <= cnt + CW'(1);
                if (state == 4'd2 && !gen_done) begin
                    phrase   <= {1'b0, ga, gop, 1'b0, gb, SYM_EQ, SYM_Q};
                    result   <= gres;
                    gen_done <= 1'b1;
                end
                if (is_print && cnt >= CW'(HOLD_TICKS - 1) && (state != 4'd1 || startgame))
                    print_done <= 1'b1;
                if (is_buz && !buz_done) begin
                    if (cnt + CW'(1) < CW'(plen)) begin
                        buzzer_q <= BUZ_EN && pat[cnt[1:0] + 2'd1];
                    end else begin
                        buzzer_q <= 1'b0;
                        buz_done <= 1'b1;
                    end
                end else begin
                    buzzer_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {h5, h4, h3, h2, h1, h0} <= {6{8'hFF}};
        end else begin
            case (state)
                4'd0, 4'd1: {h5, h4, h3, h2, h1, h0} <=
                    {8'hC7, 8'h86, 8'hC1, 8'hFF, 8'hFF, glyph({2'b00, start_level})};
                4'd3, 4'd4: begin
                    h5 <= glyph({3'b000, lvl});
                    h4 <= glyph(phrase[24:20]);
                    h3 <= glyph(phrase[19:15]);
                    h2 <= glyph(phrase[14:10]);
                    h1 <= glyph(phrase[9:5]);
                    h0 <= (state == 4'd4 && response <= 4'd9) ? glyph({1'b0, response})
                                                              : glyph(phrase[4:0]);
                end
                4'd8:  {h5, h4, h3, h2, h1, h0} <= {8'hA1, 8'hA3, 8'hAB, 8'h86, 8'hFF, 8'hFF};
                4'd10: {h5, h4, h3, h2, h1, h0} <=
                    {8'h92, 8'hC6, 8'hC0, 8'hAF, 8'hFF, glyph({3'b000, score})};
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_game_io.sv
// Directed bench for calc_game_io: reset, level screen, generator, printer, buzzer, score screen.
module tb_calc_game_io;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  state;
    logic [2:0]  level, start_level;
    logic        startgame;
    logic [1:0]  score;
    logic [3:0]  response;
    logic [27:0] seed;
    logic [24:0] phrase;
    logic [3:0]  result, value;
    logic        gen_done, print_done, buz_done, buzzer;
    logic [7:0]  h5, h4, h3, h2, h1, h0;

`ifdef CALC_BUZZER_EN
    localparam bit BZ = 1'b1;
`else
    localparam bit BZ = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    calc_game_io #(.HOLD_TICKS(4)) dut (
        .clk(clk), .rst(rst), .state(state), .level(level), .start_level(start_level),
        .startgame(startgame), .score(score), .response(response), .seed(seed),
        .phrase(phrase), .result(result), .value(value), .gen_done(gen_done),
        .print_done(print_done), .buz_done(buz_done),
        .h5(h5), .h4(h4), .h3(h3), .h2(h2), .h1(h1), .h0(h0), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; state = 4'd0; level = 3'd1; start_level = 3'd1; startgame = 1'b0;
        score = 2'd0; response = 4'hF; seed = 28'd0;
        tick(2);
        checks++;
        if ({h5, h4, h3, h2, h1, h0} !== {6{8'hFF}}) begin
            failures++; $display("FAIL reset_disp got=%h exp=%h", {h5, h4, h3, h2, h1, h0}, {6{8'hFF}});
        end
        checks++;
        if ({phrase, result, value} !== {25'h1FFFFFF, 4'd0, 4'd0}) begin
            failures++; $display("FAIL reset_regs got=%h/%0d/%0d exp=1ffffff/0/0", phrase, result, value);
        end
        checks++;
        if ({gen_done, print_done, buz_done, buzzer} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {gen_done, print_done, buz_done, buzzer});
        end
    endtask

    task automatic test_level_screen;
        rst = 1'b0; state = 4'd1; start_level = 3'd2; startgame = 1'b0;
        tick(8);
        checks++;
        if ({h5, h4, h3, h2, h1, h0} !== 48'hC786C1FFFFA4) begin
            failures++; $display("FAIL level_disp got=%h exp=c786c1ffffa4", {h5, h4, h3, h2, h1, h0});
        end
        checks++;
        if (print_done !== 1'b0) begin
            failures++; $display("FAIL level_no_start got=%b exp=0", print_done);
        end
        startgame = 1'b1;
        tick(4);
        checks++;
        if (print_done !== 1'b1) begin
            failures++; $display("FAIL level_start got=%b exp=1", print_done);
        end
    endtask

    task automatic test_gen;
        logic [2:0]  lv [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
        logic [27:0] sd [4] = '{28'h0, 28'h37, 28'h55, 28'h0};
        logic [24:0] ph [4] = '{{5'd0, 5'd16, 5'd5, 5'd19, 5'd20},
                                {5'd6, 5'd17, 5'd3, 5'd19, 5'd20},
                                {5'd3, 5'd18, 5'd3, 5'd19, 5'd20},
                                {5'd0, 5'd16, 5'd5, 5'd19, 5'd20}};
        logic [3:0]  rs [4] = '{4'd5, 4'd3, 4'd9, 4'd5};
        for (int k = 0; k < 4; k++) begin
            rst = 1'b1; state = 4'd2; level = lv[k]; seed = sd[k];
            tick();
            rst = 1'b0;
            tick();
            checks++;
            if (gen_done !== 1'b0) begin
                failures++; $display("FAIL gen_early%0d got=%b exp=0", k, gen_done);
            end
            tick();
            checks++;
            if ({gen_done, phrase, result} !== {1'b1, ph[k], rs[k]}) begin
                failures++; $display("FAIL gen_vec%0d got=%b/%h/%0d exp=1/%h/%0d", k, gen_done, phrase, result, ph[k], rs[k]);
            end
            tick(3);
            checks++;
            if (gen_done !== 1'b1) begin
                failures++; $display("FAIL gen_hold%0d got=%b exp=1", k, gen_done);
            end
        end
    endtask

    task automatic test_print;
        level = 3'd1; state = 4'd3;
        tick();
        checks++;
        if (value !== 4'd5) begin
            failures++; $display("FAIL print_value got=%0d exp=5", value);
        end
        tick(3);
        checks++;
        if (print_done !== 1'b0) begin
            failures++; $display("FAIL print_hold got=%b exp=0", print_done);
        end
        tick();
        checks++;
        if (print_done !== 1'b1) begin
            failures++; $display("FAIL print_done got=%b exp=1", print_done);
        end
        checks++;
        if ({h5, h4, h3, h2, h1, h0} !== 48'hF9C08892B7AC) begin
            failures++; $display("FAIL print_q got=%h exp=f9c08892b7ac", {h5, h4, h3, h2, h1, h0});
        end
        state = 4'd4; response = 4'd7;
        tick(2);
        checks++;
        if ({h1, h0, print_done} !== {8'hB7, 8'hF8, 1'b0}) begin
            failures++; $display("FAIL print_resp got=%h/%h/%b exp=b7/f8/0", h1, h0, print_done);
        end
        response = 4'hF;
        tick();
        checks++;
        if ({h0, value} !== {8'hAC, 4'd5}) begin
            failures++; $display("FAIL print_noresp got=%h/%0d exp=ac/5", h0, value);
        end
    endtask

    task automatic test_buzzer;
        logic [3:0] st  [3] = '{4'd6, 4'd5, 4'd7};
        int         len [3] = '{2, 4, 4};
        logic [3:0] pat [3] = '{4'b0001, 4'b0111, 4'b0101};
        for (int k = 0; k < 3; k++) begin
            state = st[k];
            for (int i = 0; i < len[k]; i++) begin
                tick();
                checks++;
                if ({buzzer, buz_done} !== {BZ & pat[k][i], 1'b0}) begin
                    failures++; $display("FAIL buz_s%0d_b%0d got=%b%b exp=%b0", st[k], i, buzzer, buz_done, BZ & pat[k][i]);
                end
            end
            tick();
            checks++;
            if ({buzzer, buz_done} !== 2'b01) begin
                failures++; $display("FAIL buz_done_s%0d got=%b%b exp=01", st[k], buzzer, buz_done);
            end
        end
        tick(2);
        checks++;
        if ({buzzer, buz_done} !== 2'b01) begin
            failures++; $display("FAIL buz_stay got=%b%b exp=01", buzzer, buz_done);
        end
        state = 4'd5;
        tick(2);
        state = 4'd6;
        tick();
        checks++;
        if ({buzzer, buz_done} !== {BZ, 1'b0}) begin
            failures++; $display("FAIL buz_abort got=%b%b exp=%b0", buzzer, buz_done, BZ);
        end
        state = 4'd4;
        tick();
        checks++;
        if ({buzzer, buz_done} !== 2'b00) begin
            failures++; $display("FAIL buz_outside got=%b%b exp=00", buzzer, buz_done);
        end
    endtask

    task automatic test_sweep;
        int a, b, op, e, bad;
        for (int lv = 1; lv <= 3; lv++) begin
            for (int i = 0; i < 256; i++) begin
                level = 3'(lv); seed = 28'(i); state = 4'd2;
                tick(2);
                a = int'(phrase[24:20]); op = int'(phrase[19:15]); b = int'(phrase[14:10]);
                e = (op == 16) ? a + b : (op == 17) ? a - b : a * b;
                bad = 0;
                if (gen_done !== 1'b1 || op != 15 + lv || a > 9 || b > 9) bad = 1;
                if (lv == 3 && (a > 3 || b > 3)) bad = 1;
                if (int'(result) != e || result > 4'd9 || e < 0) bad = 1;
                checks++;
                if (bad != 0) begin
                    failures++; $display("FAIL sweep_l%0d_s%0d got=%h/%0d exp=A op B=%0d", lv, i, phrase, result, e);
                end
                state = 4'd3;
                tick();
            end
        end
    endtask

    task automatic test_end_score;
        state = 4'd8;
        tick(2);
        checks++;
        if ({h5, h4, h3, h2, h1, h0} !== 48'hA1A3AB86FFFF) begin
            failures++; $display("FAIL end_disp got=%h exp=a1a3ab86ffff", {h5, h4, h3, h2, h1, h0});
        end
        state = 4'd10; score = 2'd3;
        tick(4);
        checks++;
        if (print_done !== 1'b0) begin
            failures++; $display("FAIL score_hold got=%b exp=0", print_done);
        end
        tick();
        checks++;
        if ({print_done, h5, h4, h3, h2, h1, h0} !== {1'b1, 48'h92C6C0AFFFB0}) begin
            failures++; $display("FAIL score_disp got=%b/%h exp=1/92c6c0afffb0", print_done, {h5, h4, h3, h2, h1, h0});
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({h5, h4, h3, h2, h1, h0, gen_done, print_done, buz_done, buzzer} !== {{6{8'hFF}}, 4'b0000}) begin
            failures++; $display("FAIL midrst got=%h/%b exp=ffffffffffff/0000", {h5, h4, h3, h2, h1, h0}, {gen_done, print_done, buz_done, buzzer});
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_level_screen();
        test_gen();
        test_print();
        test_buzzer();
        test_sweep();
        test_end_score();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
